trap_ctrl: RTL

- Trap sequencer that sits directly upstream of the CSR register file and drives its trap CSR read/write channel.
- Accepts synchronous exceptions (ecall, ebreak, illegal instruction), the already-masked interrupt requests and global MIE from the CSR block, and mret from decode.
- Performs the mepc/mcause/mtval/mstatus update sequence.
- Stalls the pipeline and issues a single PC redirect to mtvec, or to mepc on return.

---
 rtl/trap_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Trap sequencer feeding the CSR trap read/write channel.
// On an exception or interrupt it writes mepc, mcause, mtval and mstatus,
// one CSR per cycle, and then redirects the PC to mtvec. On mret it restores
// MIE from MPIE and redirects the PC to mepc. The pipeline is held for the
// whole sequence, starting in the accept cycle itself.
module trap_ctrl #(
  parameter int                    CSR_ADDR_W   = 12,
  parameter logic [CSR_ADDR_W-1:0] ADDR_MSTATUS = 12'h300,
  parameter logic [CSR_ADDR_W-1:0] ADDR_MTVEC   = 12'h305,
  parameter logic [CSR_ADDR_W-1:0] ADDR_MEPC    = 12'h341,
  parameter logic [CSR_ADDR_W-1:0] ADDR_MCAUSE  = 12'h342,
  parameter logic [CSR_ADDR_W-1:0] ADDR_MTVAL   = 12'h343
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ecall_i,
  input  logic                  ebreak_i,
  input  logic                  illegal_i,
  input  logic [31:0]           inst_i,
  input  logic [31:0]           inst_pc_i,
  input  logic [31:0]           pc_next_i,
  input  logic                  mret_i,
  input  logic                  hx_valid,
  input  logic                  ex_trap_valid_i,
  input  logic                  soft_trap_valid_i,
  input  logic                  tcmp_trap_valid_i,
  input  logic                  mstatus_MIE3,
  input  logic [31:0]           mepc_i,
  output logic                  trap_csr_we_o,
  output logic [CSR_ADDR_W-1:0] trap_csr_addr_o,
  output logic [31:0]           trap_csr_wdata_o,
  input  logic [31:0]           trap_csr_rdata_i,
  output logic                  hold_o,
  output logic                  jump_o,
  output logic [31:0]           jump_addr_o
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, JUMP, R_MSTATUS, R_JUMP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;

  logic exc_any;
  logic irq_take;
  logic accept_trap;
  logic accept_mret;
  logic accept;

  // Mode bits in rdata[1:0] are ignored: only direct-mode vectoring is supported.
  logic unused_rdata_bits;
  assign unused_rdata_bits = ^trap_csr_rdata_i[1:0];

  // Acceptance decision; gated by rst so every output reads 0 while reset is held.
  always_comb begin
    exc_any     = illegal_i | ebreak_i | ecall_i;
    irq_take    = hx_valid & mstatus_MIE3 &
                  (ex_trap_valid_i | soft_trap_valid_i | tcmp_trap_valid_i);
    accept_trap = ~rst & (state_q == IDLE) & (exc_any | (~mret_i & irq_take));
    accept_mret = ~rst & (state_q == IDLE) & ~exc_any & mret_i;
    accept      = accept_trap | accept_mret;
  end

  // Next state and latched trap context (cause/epc/tval captured on accept).
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    case (state_q)
      IDLE: begin
        if (accept_trap) begin
          state_d = W_MEPC;
          if (illegal_i) begin
            cause_d = 32'd2;
            epc_d   = inst_pc_i;
            tval_d  = inst_i;
          end else if (ebreak_i) begin
            cause_d = 32'd3;
            epc_d   = inst_pc_i;
            tval_d  = inst_pc_i;
          end else if (ecall_i) begin
            cause_d = 32'd11;
            epc_d   = inst_pc_i;
            tval_d  = 32'd0;
          end else begin
            if (ex_trap_valid_i)        cause_d = 32'h8000_000B;
            else if (soft_trap_valid_i) cause_d = 32'h8000_0003;
            else                        cause_d = 32'h8000_0007;
            epc_d  = pc_next_i;
            tval_d = 32'd0;
          end
        end else if (accept_mret) begin
          state_d = R_MSTATUS;
        end
      end
      W_MEPC:    state_d = W_MCAUSE;
      W_MCAUSE:  state_d = W_MTVAL;
      W_MTVAL:   state_d = W_MSTATUS;
      W_MSTATUS: state_d = JUMP;
      JUMP:      state_d = IDLE;
      R_MSTATUS: state_d = R_JUMP;
      R_JUMP:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State and context registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= 32'd0;
      epc_q   <= 32'd0;
      tval_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
    end
  end

  // CSR channel and redirect decode; mstatus and mtvec are read combinationally.
  always_comb begin
    trap_csr_we_o    = 1'b0;
    trap_csr_addr_o  = '0;
    trap_csr_wdata_o = 32'd0;
    jump_o           = 1'b0;
    jump_addr_o      = 32'd0;
    case (state_q)
      W_MEPC: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = ADDR_MEPC;
        trap_csr_wdata_o = epc_q;
      end
      W_MCAUSE: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = ADDR_MCAUSE;
        trap_csr_wdata_o = cause_q;
      end
      W_MTVAL: begin
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = ADDR_MTVAL;
        trap_csr_wdata_o = tval_q;
      end
      W_MSTATUS: begin
        // MPIE <= MIE, MIE <= 0
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = ADDR_MSTATUS;
        trap_csr_wdata_o = {24'h0, trap_csr_rdata_i[3], 3'h0, 1'b0, 3'h0};
      end
      JUMP: begin
        trap_csr_addr_o = ADDR_MTVEC;
        jump_o          = 1'b1;
        jump_addr_o     = {trap_csr_rdata_i[31:2], 2'b00};
      end
      R_MSTATUS: begin
        // MIE <= MPIE, MPIE <= 1
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = ADDR_MSTATUS;
        trap_csr_wdata_o = {24'h0, 1'b1, 3'h0, trap_csr_rdata_i[7], 3'h0};
      end
      R_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = mepc_i;
      end
      default: ;
    endcase
    hold_o = (state_q != IDLE) | accept;
  end

endmodule
